imm_extend_pipe: RTL and testbench

Parametrised, registered immediate-generation stage for the MIPS datapath. It replaces the fixed 16-to-32 combinational extender with a unit that does the following:
- selects one of five extension modes per transaction;
- carries a valid/ready handshake with a 2-entry skid buffer, so a downstream stall never drops or duplicates an immediate;
- keeps a saturating count of delivered results.

It sits between instruction decode and the ALU/branch-target operand mux.

---
 rtl/imm_extend_pipe_if.sv | 28 ++
 rtl/imm_extend_pipe.sv | 101 ++++++++++
 tb/tb_imm_extend_pipe.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for the immediate-extension stage: decode-side request
// fields plus the ALU-side result, ready/valid in both directions.
interface imm_extend_pipe_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  imm_in;
  logic [4:0]        shamt_in;
  logic [2:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_mode_err;
  logic [CNT_W-1:0]  xfer_count;

  modport master (
    output in_valid, imm_in, shamt_in, mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode_err, xfer_count
  );

  modport slave (
    input  in_valid, imm_in, shamt_in, mode, out_ready,
    output in_ready, out_valid, out_data, out_mode_err, xfer_count
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator: five extension modes, valid/ready with a
// one-entry skid behind the output register, saturating delivery counter.
module imm_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  imm_extend_pipe_if.slave    bus
);

  localparam logic [2:0] MODE_SIGN   = 3'd0;
  localparam logic [2:0] MODE_ZERO   = 3'd1;
  localparam logic [2:0] MODE_UPPER  = 3'd2;
  localparam logic [2:0] MODE_BRANCH = 3'd3;
  localparam logic [2:0] MODE_SHAMT  = 3'd4;

  localparam int               EXT_W   = DATA_W - IMM_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] sign_ext;
  logic [DATA_W-1:0] ext_data;
  logic              ext_err;

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              main_err;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_err;
  logic [CNT_W-1:0]  count;

  logic acc;
  logic drn;

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a value unassigned and infer a latch.
    sign_ext = {{EXT_W{bus.imm_in[IMM_W-1]}}, bus.imm_in};
    ext_data = '0;
    ext_err  = 1'b0;
    case (bus.mode)
      MODE_SIGN:   ext_data = sign_ext;
      MODE_ZERO:   ext_data = {{EXT_W{1'b0}}, bus.imm_in};
      MODE_UPPER:  ext_data = {bus.imm_in, {EXT_W{1'b0}}};
      MODE_BRANCH: ext_data = {sign_ext[DATA_W-3:0], 2'b00};
      MODE_SHAMT:  ext_data = {{(DATA_W-5){1'b0}}, bus.shamt_in};
      default:     ext_err  = 1'b1;
    endcase
  end

  // Ready depends only on stored state, never on out_ready.
  assign bus.in_ready     = !skid_valid && !reset;
  assign acc              = bus.in_valid && bus.in_ready;
  assign drn              = main_valid && bus.out_ready;

  assign bus.out_valid    = main_valid;
  assign bus.out_data     = main_data;
  assign bus.out_mode_err = main_err;
  assign bus.xfer_count   = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      count      <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every branch below reads the
      // pre-edge values of main_* and skid_* regardless of statement order.
      if (skid_valid) begin
        if (drn) begin
          main_data  <= skid_data;
          main_err   <= skid_err;
          skid_valid <= 1'b0;
        end
      end else if (!main_valid || drn) begin
        if (acc) begin
          main_valid <= 1'b1;
          main_data  <= ext_data;
          main_err   <= ext_err;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (acc) begin
        skid_valid <= 1'b1;
        skid_data  <= ext_data;
        skid_err   <= ext_err;
      end

      if (drn && count != CNT_MAX) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed vectors, backpressure, random traffic
// against a queue-based reference, counter saturation and a 64-bit variant.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  typedef struct {
    logic [63:0] d;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   model_cnt = 0;

  imm_extend_pipe_if #(.DATA_W(32), .IMM_W(16), .CNT_W(16)) bus0 ();
  imm_extend_pipe_if #(.DATA_W(32), .IMM_W(16), .CNT_W(4))  bus1 ();
  imm_extend_pipe_if #(.DATA_W(64), .IMM_W(16), .CNT_W(16)) bus2 ();

  imm_extend_pipe #(.DATA_W(32), .IMM_W(16), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  imm_extend_pipe #(.DATA_W(32), .IMM_W(16), .CNT_W(4))  u1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  imm_extend_pipe #(.DATA_W(64), .IMM_W(16), .CNT_W(16)) u2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arithmetic description of the extension rules.
  function automatic logic [63:0] ref_ext(input int dw, input int iw, input logic [2:0] m,
                                          input logic [63:0] imm, input logic [4:0] sh,
                                          output logic err);
    longint      s;
    logic [63:0] mask;
    logic [63:0] r;
    mask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw) - 64'd1);
    s = longint'(imm);
    if (imm[iw-1]) s = s - (longint'(1) << iw);
    err = (m > 3'd4);
    case (m)
      3'd0:    r = 64'(s);
      3'd1:    r = imm;
      3'd2:    r = imm << (dw - iw);
      3'd3:    r = 64'(s * 4);
      3'd4:    r = 64'(sh);
      default: r = 64'd0;
    endcase
    return r & mask;
  endfunction

  // One clock of u0 traffic with scoreboard update; ends #1 after the edge.
  task automatic cyc(output bit acc);
    bit          drn;
    bit          hold;
    logic [31:0] held;
    logic        held_err;
    logic        err;
    exp_t        e;
    acc      = bus0.in_valid && bus0.in_ready;
    drn      = bus0.out_valid && bus0.out_ready;
    hold     = bus0.out_valid && !bus0.out_ready;
    held     = bus0.out_data;
    held_err = bus0.out_mode_err;
    if (drn) begin
      check("drain_has_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("fifo_data", 64'(bus0.out_data), e.d);
        check("fifo_err", 64'(bus0.out_mode_err), 64'(e.e));
      end
      if (model_cnt < 65535) model_cnt++;
    end
    if (acc) begin
      e.d = ref_ext(32, 16, bus0.mode, 64'(bus0.imm_in), bus0.shamt_in, err);
      e.e = err;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (hold) begin
      check("hold_valid", 64'(bus0.out_valid), 64'd1);
      check("hold_data", 64'(bus0.out_data), 64'(held));
      check("hold_err", 64'(bus0.out_mode_err), 64'(held_err));
    end
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit acc;
    int cnt0;
    int n;

    vecs[0] = '{3'd0, 16'h8001, 5'd0,  32'hFFFF8001, 1'b0};
    vecs[1] = '{3'd1, 16'h8001, 5'd0,  32'h00008001, 1'b0};
    vecs[2] = '{3'd2, 16'h1234, 5'd0,  32'h12340000, 1'b0};
    vecs[3] = '{3'd3, 16'hFFFF, 5'd0,  32'hFFFFFFFC, 1'b0};
    vecs[4] = '{3'd3, 16'h7FFF, 5'd0,  32'h0001FFFC, 1'b0};
    vecs[5] = '{3'd4, 16'h0000, 5'd31, 32'h0000001F, 1'b0};
    vecs[6] = '{3'd6, 16'hFFFF, 5'd0,  32'h00000000, 1'b1};
    vecs[7] = '{3'd0, 16'h0001, 5'd0,  32'h00000001, 1'b0};

    reset = 1'b1;
    bus0.in_valid = 0; bus0.imm_in = '0; bus0.shamt_in = '0; bus0.mode = '0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.imm_in = '0; bus1.shamt_in = '0; bus1.mode = '0; bus1.out_ready = 0;
    bus2.in_valid = 0; bus2.imm_in = '0; bus2.shamt_in = '0; bus2.mode = '0; bus2.out_ready = 0;

    // Reset state
    #2;
    check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    check("rst_out_data", 64'(bus0.out_data), 64'd0);
    check("rst_out_err", 64'(bus0.out_mode_err), 64'd0);
    check("rst_count", 64'(bus0.xfer_count), 64'd0);
    check("rst_in_ready", 64'(bus0.in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus0.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed single transfers: one-cycle latency, then drain
    foreach (vecs[i]) begin
      bus0.out_ready = 1;
      bus0.in_valid  = 1;
      bus0.mode      = vecs[i].mode;
      bus0.imm_in    = vecs[i].imm;
      bus0.shamt_in  = vecs[i].sh;
      cyc(acc);
      bus0.in_valid = 0;
      check($sformatf("vec%0d_valid", i), 64'(bus0.out_valid), 64'd1);
      check($sformatf("vec%0d_data", i), 64'(bus0.out_data), 64'(vecs[i].exp_d));
      check($sformatf("vec%0d_err", i), 64'(bus0.out_mode_err), 64'(vecs[i].exp_e));
      cyc(acc);
      check($sformatf("vec%0d_drained", i), 64'(bus0.out_valid), 64'd0);
      check($sformatf("vec%0d_count", i), 64'(bus0.xfer_count), 64'(i + 1));
    end

    // Backpressure: A held, B to skid, C waits for in_ready
    cnt0 = int'(bus0.xfer_count);
    bus0.out_ready = 0;
    bus0.mode = 3'd0;
    bus0.in_valid = 1; bus0.imm_in = 16'd1;
    cyc(acc);
    check("bp_a_data", 64'(bus0.out_data), 64'd1);
    check("bp_ready_after_a", 64'(bus0.in_ready), 64'd1);
    bus0.imm_in = 16'd2;
    cyc(acc);
    check("bp_ready_after_b", 64'(bus0.in_ready), 64'd0);
    check("bp_a_still", 64'(bus0.out_data), 64'd1);
    bus0.imm_in = 16'd3;
    cyc(acc);
    check("bp_c_not_taken", 64'(acc), 64'd0);
    check("bp_ready_low", 64'(bus0.in_ready), 64'd0);
    bus0.out_ready = 1;
    cyc(acc);
    check("bp_out_b", 64'(bus0.out_data), 64'd2);
    cyc(acc);
    check("bp_c_taken", 64'(acc), 64'd1);
    bus0.in_valid = 0;
    check("bp_out_c", 64'(bus0.out_data), 64'd3);
    cyc(acc);
    check("bp_empty", 64'(bus0.out_valid), 64'd0);
    check("bp_count", 64'(bus0.xfer_count), 64'(cnt0 + 3));

    // Random traffic against the queue reference
    for (int k = 0; k < 400; k++) begin
      bus0.in_valid  = ($urandom_range(0, 3) != 0);
      bus0.out_ready = ($urandom_range(0, 1) != 0);
      bus0.mode      = 3'($urandom_range(0, 7));
      bus0.imm_in    = 16'($urandom);
      bus0.shamt_in  = 5'($urandom);
      cyc(acc);
    end
    bus0.in_valid = 0;
    bus0.out_ready = 1;
    n = 0;
    while (q.size() > 0 && n < 8) begin
      cyc(acc);
      n++;
    end
    check("rand_drain_empty", 64'(q.size()), 64'd0);
    check("rand_out_idle", 64'(bus0.out_valid), 64'd0);
    check("rand_count", 64'(bus0.xfer_count), 64'(model_cnt));

    // Reset while both entries are full
    bus0.out_ready = 0;
    bus0.in_valid = 1; bus0.mode = 3'd0; bus0.imm_in = 16'd5;
    cyc(acc);
    bus0.imm_in = 16'd6;
    cyc(acc);
    bus0.in_valid = 0;
    check("stall_full_ready", 64'(bus0.in_ready), 64'd0);
    check("stall_full_valid", 64'(bus0.out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus0.out_valid), 64'd0);
    check("async_rst_count", 64'(bus0.xfer_count), 64'd0);
    check("async_rst_ready", 64'(bus0.in_ready), 64'd0);
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rerst_in_ready", 64'(bus0.in_ready), 64'd1);
    bus0.out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      cyc(acc);
      check("no_stale", 64'(bus0.out_valid), 64'd0);
    end

    // Saturating 4-bit counter
    bus1.in_valid = 1; bus1.out_ready = 1; bus1.mode = 3'd0;
    for (int k = 0; k < 10; k++) begin
      bus1.imm_in = 16'(k);
      @(posedge clk);
      #1;
    end
    check("sat_count_9", 64'(bus1.xfer_count), 64'd9);
    for (int k = 10; k < 20; k++) begin
      bus1.imm_in = 16'(k);
      @(posedge clk);
      #1;
    end
    bus1.in_valid = 0;
    @(posedge clk);
    #1;
    check("sat_count_15", 64'(bus1.xfer_count), 64'd15);
    repeat (3) @(posedge clk);
    #1;
    check("sat_count_held", 64'(bus1.xfer_count), 64'd15);

    // 64-bit output width
    begin
      logic        e64;
      logic [63:0] r64;
      bus2.out_ready = 1; bus2.in_valid = 1; bus2.mode = 3'd0; bus2.imm_in = 16'h8000;
      @(posedge clk);
      #1;
      check("w64_sign_data", bus2.out_data, 64'hFFFF_FFFF_FFFF_8000);
      check("w64_sign_err", 64'(bus2.out_mode_err), 64'd0);
      bus2.mode = 3'd2; bus2.imm_in = 16'h1234;
      r64 = ref_ext(64, 16, 3'd2, 64'h1234, 5'd0, e64);
      @(posedge clk);
      #1;
      bus2.in_valid = 0;
      check("w64_upper_data", bus2.out_data, r64);
      check("w64_upper_err", 64'(bus2.out_mode_err), 64'(e64));
      @(posedge clk);
      #1;
      check("w64_count", 64'(bus2.xfer_count), 64'd2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
